ex_muldiv_ctrl: RTL and testbench
=================================

# ex_muldiv_ctrl

Multi-cycle RV32M multiply/divide sequencer attached beside the execute-stage ALU. It accepts forwarded operands from EX and runs a 32-iteration shift-add multiply or restoring divide. While busy it holds the front of the pipeline with `stall_ex`. It returns a single-cycle `result_valid` pulse with the result and destination register for the EX/MEM latch.

## Interface
Parameters:
- `XLEN`, 32, operand/result width; only 32 is supported.
- `ITERS`, 32, iteration count; must equal `XLEN`.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  valid M-extension instruction in EX this cycle.
- `md_op`  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a`  in  32  forwarded rs1 value.
- `op_b`  in  32  forwarded rs2 value.
- `rd_in`  in  5  destination register.
- `flush`  in  1  kill in-flight operation (branch redirect/trap).
- `stall_ex`  out  1  hold PC, IF/ID and ID/EX.
- `busy`  out  1  FSM not in IDLE.
- `result_valid`  out  1  one-cycle result strobe.
- `result`  out  32  result; held until next `result_valid`.
- `rd_out`  out  5  destination register qualified by `result_valid`.

## Operation
- FSM states: IDLE, MUL_IT, DIV_IT, FIX, DONE.
- IDLE:
  - `start && !flush` latches `md_op`, `rd_in`, operand magnitudes and sign bits.
  - Goes to MUL_IT (`md_op[2]==0`) or DIV_IT, with the iteration counter cleared.
- Signedness:
  - `op_a` is signed for MUL/MULH/MULHSU/DIV/REM.
  - `op_b` is signed for MUL/MULH/DIV/REM.
  - Unsigned operands are used as-is.
- MUL_IT: one shift-add step per cycle on a 64-bit accumulator. After 32 steps go to FIX.
- DIV_IT: one restoring shift-subtract step per cycle, giving a 32-bit quotient and remainder. After 32 steps go to FIX.
- FIX sign correction:
  - Product is negated if `sa^sb`.
  - Quotient is negated if `sa^sb`; remainder is negated if `sa`.
  - Then select: MUL low 32 bits; MULH* high 32 bits; DIV*/REM* quotient/remainder.
- DONE: `result_valid=1` for exactly one cycle, then IDLE.
- Special cases are detected in IDLE at start; they skip iteration and go straight to DONE:
  - Divide by zero: quotient `0xFFFFFFFF`, remainder = `op_a`.
  - Signed overflow (`0x80000000 / 0xFFFFFFFF`, DIV/REM only): quotient `0x80000000`, remainder 0.
- Flush:
  - From any state: go to IDLE next cycle; `result_valid` suppressed.
  - Flush beats start in the same cycle.
- `start` while not IDLE is ignored; the pipeline guarantees this cannot occur under `stall_ex`.
- Reset values (including reset mid-operation): state IDLE; `stall_ex`, `busy`, `result_valid` = 0; `result` = 0; `rd_out` = 0; counter 0.

## Timing
- Start sampled at cycle T.
- Normal path:
  - Iterations occupy T+1..T+32.
  - FIX at T+33.
  - DONE/`result_valid` at T+34.
- Special-case path: `result_valid` at T+1.
- `stall_ex = (state==IDLE && start && !flush) || (state ∉ {IDLE, DONE})`. It is combinational from `start` in cycle T, and low in the DONE cycle so the instruction advances with its result.
- `busy` is registered-state only; high T+1 through the DONE cycle.
- Back-to-back: a new `start` is accepted the cycle after DONE (IDLE), not during DONE.
- Counter is 6 bits; terminal value 31 transitions on that edge, with no wrap.

## Structure
- Package `ex_md_pkg` holds:
  - `md_op` encodings (localparams);
  - state enum;
  - `ITERS`;
  - special-case constants (`0xFFFFFFFF`, `0x80000000`).
- One sub-module, `md_iter_step`: combinational single-step unit producing next accumulator/partial-remainder and quotient bit for both mul and div modes.
- Top holds FSM, counter, sign/magnitude capture, FIX negation and output registers.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3) at T → `result=0xFFFFFFEB`, `result_valid` only at T+34, `stall_ex` high T..T+33.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → `0xFFFFFFFE`; MULH same operands → `0x00000000`; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → `0xFFFFFFFF`.
- DIV 0xFFFFFFF9 (−7) / 2 → `0xFFFFFFFD`; REM same → `0xFFFFFFFF`; DIVU 100/7 → 14, REMU → 2.
- DIVU 5/0 → `0xFFFFFFFF` at T+1; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → `0x80000000`, REM → 0, both at T+1.
- Flush at T+10 of a DIV → no `result_valid`, `stall_ex` low at T+11, `busy` low at T+11; a new start at T+11 completes normally at T+45 with correct `rd_out`.
- `rst_n=0` at T+20 of a MUL → all outputs zero next cycle; first start after release yields the correct result and `rd_out`.

Source files
------------

// File: rtl/ex_md_pkg.sv
// Shared encodings, state type and constants for the EX-stage multiply/divide sequencer.
package ex_md_pkg;

    localparam int XLEN  = 32;
    localparam int ITERS = 32;

    // funct3 encodings of the RV32M instructions
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] OVF_QUOT  = 32'h8000_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_IT,
        S_DIV_IT,
        S_FIX,
        S_DONE
    } md_state_e;

endpackage

// File: rtl/md_iter_step.sv
// One iteration of shift-add multiply or restoring divide on a shared 2*XLEN accumulator.
module md_iter_step
#(
    parameter int XLEN = 32
) (
    input  logic              div_mode,
    input  logic [2*XLEN-1:0] acc_in,
    input  logic [XLEN-1:0]   operand,
    output logic [2*XLEN-1:0] acc_out,
    output logic              q_bit
);

    logic [XLEN:0] add_sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        acc_out = '0;
        q_bit   = 1'b0;

        // Multiply: {hi,lo} holds partial product and remaining multiplier bits.
        add_sum = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, operand} : '0);

        // Divide: {rem,dividend} shifts left; a borrow in diff means the divisor did not fit.
        shifted = acc_in[2*XLEN-1:XLEN-1];
        diff    = shifted - {1'b0, operand};

        if (div_mode) begin
            q_bit   = ~diff[XLEN];
            acc_out = {(q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0]), acc_in[XLEN-2:0], 1'b0};
        end else begin
            acc_out = {add_sum, acc_in[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// RV32M multi-cycle multiply/divide sequencer beside the EX ALU; stalls the front end while busy
// and returns a one-cycle result strobe with its destination register.
module ex_muldiv_ctrl
    import ex_md_pkg::*;
#(
    parameter int XLEN  = ex_md_pkg::XLEN,
    parameter int ITERS = ex_md_pkg::ITERS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      md_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            stall_ex,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam logic [5:0] LAST_ITER = 6'(ITERS - 1);

    md_state_e         state_q, state_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [4:0]        rd_q, rd_d;
    logic              sa_q, sa_d;
    logic              sb_q, sb_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        rd_out_q, rd_out_d;

    logic              a_neg, b_neg, ovf;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [2*XLEN-1:0] step_acc, prod_fix;
    logic              step_q_bit;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;

    md_iter_step #(.XLEN(XLEN)) u_step (
        .div_mode (state_q == S_DIV_IT),
        .acc_in   (acc_q),
        .operand  (opnd_q),
        .acc_out  (step_acc),
        .q_bit    (step_q_bit)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        rd_d     = rd_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        result_d = result_q;
        rd_out_d = rd_out_q;

        a_neg = !(md_op inside {OP_MULHU, OP_DIVU, OP_REMU}) && op_a[XLEN-1];
        b_neg = (md_op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM}) && op_b[XLEN-1];
        a_mag = a_neg ? -op_a : op_a;
        b_mag = b_neg ? -op_b : op_b;
        ovf   = (md_op inside {OP_DIV, OP_REM}) && (op_a == OVF_QUOT) && (op_b == DIV0_QUOT);

        prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;
        quo_fix  = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

        case (op_q)
            OP_MUL:                       fix_result = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_result = quo_fix;
            default:                      fix_result = rem_fix;
        endcase

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d  = md_op;
                    rd_d  = rd_in;
                    sa_d  = a_neg;
                    sb_d  = b_neg;
                    cnt_d = '0;
                    if (!md_op[2]) begin
                        acc_d   = {{XLEN{1'b0}}, b_mag};
                        opnd_d  = a_mag;
                        state_d = S_MUL_IT;
                    end else if (op_b == '0) begin
                        result_d = md_op[1] ? op_a : DIV0_QUOT;
                        rd_out_d = rd_in;
                        state_d  = S_DONE;
                    end else if (ovf) begin
                        result_d = md_op[1] ? '0 : OVF_QUOT;
                        rd_out_d = rd_in;
                        state_d  = S_DONE;
                    end else begin
                        acc_d   = {{XLEN{1'b0}}, a_mag};
                        opnd_d  = b_mag;
                        state_d = S_DIV_IT;
                    end
                end
            end
            S_MUL_IT, S_DIV_IT: begin
                acc_d = step_acc | {{(2*XLEN-1){1'b0}}, step_q_bit};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST_ITER) state_d = S_FIX;
            end
            S_FIX: begin
                result_d = fix_result;
                rd_out_d = rd_q;
                state_d  = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A flush overrides everything, including a start in the same cycle.
        if (flush) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            result_d = result_q;
            rd_out_d = rd_out_q;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is written only with non-blocking assignments.
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
        end
    end

    assign stall_ex     = ((state_q == S_IDLE) && start && !flush) ||
                          ((state_q != S_IDLE) && (state_q != S_DONE));
    assign busy         = (state_q != S_IDLE);
    assign result_valid = (state_q == S_DONE) && !flush;
    assign result       = result_q;
    assign rd_out       = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Self-checking bench for ex_muldiv_ctrl: directed test-plan steps plus random operations
// compared against an arithmetic reference model.
module tb_ex_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_in;
    logic        flush;
    logic        stall_ex;
    logic        busy;
    logic        result_valid;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int checks = 0;
    int errors = 0;

    ex_muldiv_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .md_op        (md_op),
        .op_a         (op_a),
        .op_b         (op_b),
        .rd_in        (rd_in),
        .flush        (flush),
        .stall_ex     (stall_ex),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result),
        .rd_out       (rd_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: RV32M semantics computed with wide integer arithmetic.
    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [63:0] p;
        longint      sa, sb, ua, ub;
        int          ia, ib;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        ia  = $signed(a);
        ib  = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Issues one operation at a negedge in IDLE and follows it to completion.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
        int          lat;
        int          exp_lat;
        bit          held;
        logic [31:0] exp;
        exp     = ref_md(op, a, b);
        exp_lat = (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
                  ? 1 : 34;
        md_op = op; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
        #1;
        check({tag, "/stall_at_start"}, 32'(stall_ex), 32'd1);
        @(negedge clk);
        start = 1'b0; op_a = $urandom; op_b = $urandom; rd_in = 5'($urandom);
        lat  = 1;
        held = 1'b1;
        while (!result_valid && lat < 40) begin
            if (!(stall_ex && busy)) held = 1'b0;
            @(negedge clk);
            lat++;
        end
        check({tag, "/stall_busy_held"}, 32'(held), 32'd1);
        check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "/result"}, result, exp);
        check({tag, "/rd_out"}, 32'(rd_out), 32'(rd));
        check({tag, "/stall_in_done"}, 32'(stall_ex), 32'd0);
        check({tag, "/busy_in_done"}, 32'(busy), 32'd1);
        @(negedge clk);
        check({tag, "/valid_one_cycle"}, 32'(result_valid), 32'd0);
        check({tag, "/idle_after"}, 32'(busy), 32'd0);
        check({tag, "/result_held"}, result, exp);
    endtask

    initial begin
        bit          seen_valid;
        logic [2:0]  r_op;
        logic [31:0] r_a, r_b;

        rst_n = 1'b0; start = 1'b0; flush = 1'b0;
        md_op = '0; op_a = '0; op_b = '0; rd_in = '0;
        repeat (3) @(negedge clk);
        check("reset/busy", 32'(busy), 32'd0);
        check("reset/stall", 32'(stall_ex), 32'd0);
        check("reset/valid", 32'(result_valid), 32'd0);
        check("reset/result", result, 32'd0);
        check("reset/rd_out", 32'(rd_out), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("mul_7_m3",  3'd0, 32'd7,          32'hFFFF_FFFD, 5'd1);
        run_op("mulhu_ff",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2);
        run_op("mulh_ff",   3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3);
        run_op("mulhsu_ff", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd4);
        run_op("div_m7_2",  3'd4, 32'hFFFF_FFF9,  32'd2,         5'd5);
        run_op("rem_m7_2",  3'd6, 32'hFFFF_FFF9,  32'd2,         5'd6);
        run_op("divu_100",  3'd5, 32'd100,        32'd7,         5'd7);
        run_op("remu_100",  3'd7, 32'd100,        32'd7,         5'd8);
        run_op("divu_by0",  3'd5, 32'd5,          32'd0,         5'd9);
        run_op("rem_by0",   3'd6, 32'd5,          32'd0,         5'd10);
        run_op("div_ovf",   3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd11);
        run_op("rem_ovf",   3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12);

        // Flush of a divide at T+10, new start at T+11.
        md_op = 3'd4; op_a = 32'd1000; op_b = 32'd3; rd_in = 5'd13; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen_valid = 1'b0;
        repeat (9) begin
            if (result_valid) seen_valid = 1'b1;
            @(negedge clk);
        end
        flush = 1'b1;
        #1;
        check("flush/valid_suppressed", 32'(result_valid | seen_valid), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        check("flush/stall_low", 32'(stall_ex), 32'd0);
        check("flush/busy_low", 32'(busy), 32'd0);
        check("flush/no_valid", 32'(result_valid), 32'd0);
        run_op("after_flush", 3'd6, 32'hFFFF_FC18, 32'd7, 5'd14);

        // Reset during a multiply at T+20.
        md_op = 3'd0; op_a = 32'd12345; op_b = 32'd678; rd_in = 5'd15; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst/busy", 32'(busy), 32'd0);
        check("midrst/stall", 32'(stall_ex), 32'd0);
        check("midrst/valid", 32'(result_valid), 32'd0);
        check("midrst/result", result, 32'd0);
        check("midrst/rd_out", 32'(rd_out), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("after_rst", 3'd0, 32'd12345, 32'd678, 5'd16);

        for (int i = 0; i < 30; i++) begin
            r_op = 3'($urandom_range(0, 7));
            r_a  = $urandom;
            r_b  = $urandom;
            case ($urandom_range(0, 7))
                0: r_b = 32'd0;
                1: begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
                2: r_b = 32'($urandom_range(1, 20));
                3: r_a = 32'h8000_0000;
                default: ;
            endcase
            run_op($sformatf("rand%0d_op%0d", i, r_op), r_op, r_a, r_b, 5'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
